rv_decode_stage: RTL
====================

# rv_decode_stage

Parametrised, handshaked RISC-V RV32I/RV64I instruction decode stage that sits between fetch and register-read/execute. It decodes one instruction per cycle into register indices, control fields and a fully formed, sign-extended XLEN immediate, and flags illegal encodings instead of silently holding stale values. Decoded results are buffered in a small output FIFO so fetch is decoupled from downstream stalls. The stage also supports a single-cycle pipeline flush.

## Interface
- XLEN, 32, datapath width for immediate and PC (32 or 64)
- BUF_DEPTH, 2, output buffer entries (power of two, ≥2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and incoming instructions this cycle
- in_valid  in  1  fetch offers in_instr/in_pc
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry at head
- out_ready  in  1  consumer accepts; pop when out_valid && out_ready
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices, 0 when unused by format
- out_fn3  out  3  funct3, 0 when unused
- out_fn7_5  out  1  instr[30] for R-type, else 0
- out_imm  out  XLEN  sign-extended byte-offset immediate
- out_mem  out  2  00 none, 01 store, 10 load
- out_illegal  out  1  encoding not supported
- out_pc  out  XLEN  in_pc of head entry

## Operation
- Combinational decode of in_instr; result plus in_pc pushed into FIFO on input handshake.
- Immediates: I/JALR/load sext(i[31:20]); S sext({i[31:25],i[11:7]}); B sext({i[31],i[7],i[30:25],i[11:8],1'b0}); J sext({i[31],i[19:12],i[20],i[30:21],1'b0}); U/AUIPC sext({i[31:12],12'h0}). R-type imm = 0.
- Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111, 1100111, 0010111.
- out_illegal=1 when: i[1:0]≠11; opcode unsupported; JALR fn3≠0; R-type i[31:25] not 0000000/0100000; instruction 0x00000000. Illegal entries are still buffered and delivered, with all fields except out_opcode, out_pc and out_illegal set to 0.
- in_ready = !full && !reset. No combinational path from out_ready to in_ready.
- flush: FIFO emptied at the clock edge; a handshake in the same cycle is dropped, as is a pop in the same cycle. flush dominates push and pop.
- All out_* payload is 0 whenever out_valid=0.

## Timing
- Reset: FIFO empty, out_valid=0, in_ready=0 during reset and 1 on the first cycle after, all payload outputs 0.
- Latency: accepted at edge N → out_valid=1 in cycle N+1 when the FIFO was empty.
- Throughput: 1/cycle with out_ready held high.
- Simultaneous push and pop when neither empty nor full: count unchanged and order preserved.
- Full: in_ready=0. A pop in that cycle frees a slot visible the next cycle.
- Pointers wrap modulo BUF_DEPTH; count width is $clog2(BUF_DEPTH)+1.
- Reset mid-stream discards all entries, identical to flush.

## Structure
- Package rv_decode_pkg: opcode localparams, mem_op_e enum (MEM_NONE/MEM_STORE/MEM_LOAD), decoded_t packed struct parametrised via XLEN-sized field, and imm-format helper functions.
- Sub-module sync_fifo (WIDTH, DEPTH) with push/pop/flush/full/empty. The decode logic lives in rv_decode_stage.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), XLEN=32 → rd=1, rs1=2, fn3=0, imm=0xFFFFFFFF, mem=00, illegal=0, out_valid one cycle after accept.
- 0x00532423 (sw x5,8(x6)) → rs1=6, rs2=5, fn3=2, imm=0x00000008, mem=01, rd=0. Then 0xFFDFF06F (jal x0,-4) → imm=0xFFFFFFFC.
- 0x123451B7 (lui x3,0x12345), XLEN=64 → rd=3, imm=0x0000000012345000. Repeat with 0x800001B7 → imm=0xFFFFFFFF80000000.
- BUF_DEPTH=2, out_ready=0, three back-to-back valids → first two accepted, in_ready=0 on the third. Raise out_ready → in-order delivery, then the third is accepted.
- Two entries buffered, flush asserted together with in_valid=1 → next cycle out_valid=0, nothing accepted, in_ready=1.
- 0x00000000 and 0x0000007F → out_valid=1, out_illegal=1, rd/rs1/rs2/imm=0. Reset pulse mid-stream → out_valid=0 next cycle.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: opcodes, decoded-entry type and immediate
// helpers shared by the RV32I/RV64I decode stage.
package rv_decode_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Every base immediate fits in 32 signed bits; the stage
    // sign-extends to XLEN when the entry leaves the buffer.
    localparam int IMM_W = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_STORE = 2'b01,
        MEM_LOAD  = 2'b10
    } mem_op_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       fn3;
        logic             fn7_5;
        logic [IMM_W-1:0] imm;
        mem_op_e          mem;
        logic             illegal;
    } decoded_t;

    function automatic logic [IMM_W-1:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [IMM_W-1:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [IMM_W-1:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [IMM_W-1:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [IMM_W-1:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'h000};
    endfunction

endpackage

// File: rtl/rv_decode_stage_fifo.sv
// sync_fifo: small synchronous FIFO with flush; flush
// dominates push and pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush && !reset;
    assign do_pop  = pop && !empty && !flush && !reset;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I/RV64I decode with a buffered,
// handshaked output and single-cycle flush.
module rv_decode_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fn3,
    output logic            out_fn7_5,
    output logic [XLEN-1:0] out_imm,
    output logic [1:0]      out_mem,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    import rv_decode_pkg::*;

    localparam int EW = $bits(decoded_t) + XLEN;

    decoded_t        dec;
    decoded_t        head;
    logic [XLEN-1:0] head_pc;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;
    logic [6:0]      opc;
    logic [6:0]      fn7;
    logic            legal;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign opc = in_instr[6:0];
    assign fn7 = in_instr[31:25];

    always_comb begin
        dec   = '0;
        legal = (in_instr[1:0] == 2'b11) && (in_instr != 32'h0);
        unique case (opc)
            OP_REG: begin
                dec.rd    = in_instr[11:7];
                dec.rs1   = in_instr[19:15];
                dec.rs2   = in_instr[24:20];
                dec.fn3   = in_instr[14:12];
                dec.fn7_5 = in_instr[30];
                legal     = legal &&
                            (fn7 == 7'h00 || fn7 == 7'h20);
            end
            OP_IMM: begin
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                dec.fn3 = in_instr[14:12];
                dec.imm = imm_i(in_instr);
            end
            OP_LOAD: begin
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                dec.fn3 = in_instr[14:12];
                dec.imm = imm_i(in_instr);
                dec.mem = MEM_LOAD;
            end
            OP_STORE: begin
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
                dec.fn3 = in_instr[14:12];
                dec.imm = imm_s(in_instr);
                dec.mem = MEM_STORE;
            end
            OP_BRANCH: begin
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
                dec.fn3 = in_instr[14:12];
                dec.imm = imm_b(in_instr);
            end
            OP_JAL: begin
                dec.rd  = in_instr[11:7];
                dec.imm = imm_j(in_instr);
            end
            OP_JALR: begin
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                dec.imm = imm_i(in_instr);
                legal   = legal && (in_instr[14:12] == 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                dec.rd  = in_instr[11:7];
                dec.imm = imm_u(in_instr);
            end
            default: legal = 1'b0;
        endcase
        dec.opcode = opc;
        // Illegal words keep only opcode so nothing stale leaks out.
        if (!legal) begin
            dec         = '0;
            dec.opcode  = opc;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = !full && !reset;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign wdata     = {in_pc, dec};
    assign {head_pc, head} = rdata;

    sync_fifo #(
        .WIDTH(EW),
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .push (push),
        .pop  (pop),
        .wdata(wdata),
        .rdata(rdata),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        out_opcode  = '0;
        out_rd      = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_fn3     = '0;
        out_fn7_5   = 1'b0;
        out_imm     = '0;
        out_mem     = '0;
        out_illegal = 1'b0;
        out_pc      = '0;
        if (out_valid) begin
            out_opcode  = head.opcode;
            out_rd      = head.rd;
            out_rs1     = head.rs1;
            out_rs2     = head.rs2;
            out_fn3     = head.fn3;
            out_fn7_5   = head.fn7_5;
            out_imm     = XLEN'(signed'(head.imm));
            out_mem     = head.mem;
            out_illegal = head.illegal;
            out_pc      = head_pc;
        end
    end

endmodule
